// File: rtl/aes_pkg.sv
// aes_pkg: shared types, round constants, word helpers and the forward S-box for the inverse AES-128 key schedule.
package aes_pkg;
  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;
  typedef logic [0:3][31:0] words_t;
`ifdef AES_INV_KS_FWD_EN
  typedef enum logic [1:0] {IDLE, EMIT, FWD} state_t;
`else
  typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif
  localparam logic [0:255][7:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;
  function automatic words_t to_words(input logic [127:0] k);
    return words_t'(k);
  endfunction
  function automatic logic [127:0] to_key(input words_t w);
    return 128'(w);
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return (x == 8'h1b) ? 8'h80 : x >> 1;
  endfunction
endpackage

// File: rtl/aes_inv_key_sched_if.sv
// aes_inv_key_sched_if: start/key load and valid/ready round-key stream of the inverse key schedule.
interface aes_inv_key_sched_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;
  modport master (output start, key_in, rk_ready, input rk_out, rk_round, rk_valid, busy, done);
  modport slave  (input start, key_in, rk_ready, output rk_out, rk_round, rk_valid, busy, done);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = SBOX[a];
endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: iterative inverse AES-128 key schedule streaming round keys NR..0 over valid/ready.
// Define AES_INV_KS_FWD_EN to load the cipher key and expand forward (sharing the S-boxes) before emitting.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic clk,
  input  logic rst,
  aes_inv_key_sched_if.slave bus
);
  localparam logic [3:0] LAST = 4'(NR);
  state_t       state;
  logic [127:0] rk;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic         valid, busy, done;
  words_t       w;
  logic [31:0]  sel, rot, sub, p0;
  logic [127:0] inv_key;
  assign w = to_words(rk);
`ifdef AES_INV_KS_FWD_EN
  logic [31:0] f0, f1, f2, f3;
  assign sel = (state == FWD) ? w[3] : w[3] ^ w[2];
  assign f0 = w[0] ^ sub ^ {rcon, 24'h0};
  assign f1 = w[1] ^ f0;
  assign f2 = w[2] ^ f1;
  assign f3 = w[3] ^ f2;
`else
  assign sel = w[3] ^ w[2];
`endif
  assign rot = {sel[23:0], sel[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end
  assign p0      = w[0] ^ sub ^ {rcon, 24'h0};
  assign inv_key = to_key({p0, w[1] ^ w[0], w[2] ^ w[1], w[3] ^ w[2]});
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rk    <= '0;
      round <= '0;
      rcon  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          rk   <= bus.key_in;
          busy <= 1'b1;
`ifdef AES_INV_KS_FWD_EN
          round <= '0;
          rcon  <= RCON_FIRST;
          state <= FWD;
`else
          round <= LAST;
          rcon  <= RCON_LAST;
          valid <= 1'b1;
          state <= EMIT;
`endif
        end
`ifdef AES_INV_KS_FWD_EN
        FWD: begin
          rk    <= {f0, f1, f2, f3};
          round <= (round == LAST - 4'd1) ? LAST : round + 4'd1;
          rcon  <= (round == LAST - 4'd1) ? RCON_LAST : xtime(rcon);
          valid <= (round == LAST - 4'd1);
          state <= (round == LAST - 4'd1) ? EMIT : FWD;
        end
`endif
        EMIT: if (valid && bus.rk_ready) begin
          if (round != 4'd0) begin
            rk    <= inv_key;
            round <= round - 4'd1;
            rcon  <= inv_xtime(rcon);
          end else begin
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.rk_out   = rk;
  assign bus.rk_round = round;
  assign bus.rk_valid = valid;
  assign bus.busy     = busy;
  assign bus.done     = done;
endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
Iterative inverse AES-128 key schedule. It is the reverse direction of the forward key expansion step (key, round count -> next round key). It takes the round-10 key and walks backward one round per accepted transfer, streaming round keys 10 down to 0 to the decryption datapath over a valid/ready handshake. This gives on-the-fly decryption keys without an 11-entry key RAM.

Parameters:
NR, 10, number of AES rounds. Fixed at 10 for AES-128; other values are unsupported.
RCON_LAST, 8'h36, round constant of the final round (round NR).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse; loads key_in and begins the sequence (honoured only in IDLE)
key_in  in  128  round-NR key (cipher key when AES_INV_KS_FWD_EN is defined); word0 = [127:96]
rk_out  out  128  current round key
rk_round  out  4  round index of rk_out (10..0)
rk_valid  out  1  rk_out/rk_round valid
rk_ready  in  1  consumer accepts when rk_valid && rk_ready
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after round-0 key is accepted

Behaviour:
- Reset (async, any state): state=IDLE, rk_out=0, rk_round=0, rk_valid=0, busy=0, done=0, rcon=0.
- States: IDLE, EMIT, FWD (FWD exists only with AES_INV_KS_FWD_EN).
- IDLE + start:
  - On the next edge, rk_out<=key_in, rk_round<=NR, rcon<=RCON_LAST, rk_valid<=1, busy<=1, state<=EMIT.
  - start outside IDLE is ignored.
- EMIT, rk_valid && !rk_ready: all outputs hold (stall of any length).
- EMIT, rk_valid && rk_ready, rk_round>0: on the same edge rk_out<=inverse step, rk_round<=rk_round-1, rcon<=inv_xtime(rcon). rk_valid stays 1, so back-to-back transfers are possible at one key per cycle.
- EMIT, rk_valid && rk_ready, rk_round==0: rk_valid<=0, busy<=0, done<=1 for one cycle, state<=IDLE. rk_out retains the round-0 key.
- Inverse step, with w0..w3 = rk_out words and r = the rcon of the current round:
  - p3=w3^w2, p2=w2^w1, p1=w1^w0
  - p0=w0^SubWord(RotWord(p3))^{r,24'h0}
  - RotWord is a left rotate by one byte. SubWord is the forward S-box on each of the 4 bytes.
- inv_xtime(x): 8'h1b -> 8'h80; otherwise x>>1. Sequence: 36,1b,80,40,20,10,08,04,02,01.
- Latency: start to first rk_valid = 1 cycle; 11 transfers total; done 1 cycle after the last accept.
- Combinational path per cycle: 4 S-boxes plus XORs. No multicycle paths.

Optional Feature:
Macro AES_INV_KS_FWD_EN.
- Defined: key_in is the cipher key.
  - start -> FWD. The block runs NR forward expansion rounds, one per cycle, with rcon 01..36 and rk_valid=0, busy=1.
  - It then enters EMIT with rk_round=NR and rcon=36 exactly as above.
  - start to first rk_valid = NR+1 = 11 cycles. The S-boxes are shared between the forward and inverse steps.
- Undefined: FWD state and forward logic are absent; key_in must be the round-NR key.

Decomposition:
- Package aes_pkg holds:
  - state enum
  - RCON_FIRST=8'h01 and RCON_LAST=8'h36
  - 128-bit word-split helpers
  - the S-box table constant
- One natural sub-module: aes_sbox (8-bit in, 8-bit out, combinational), instantiated 4 times.

Test Plan:
- Load key_in=13111d7fe3944a17f307a78b4d2b30c5, start, rk_ready=1.
  - Expect rk_round=10 with that key, then rk_round=9 = 549932d1f08557681093ed9cbe2c974e on consecutive cycles.
  - Expect rk_round=0 = 000102030405060708090a0b0c0d0e0f, then done pulse, busy=0.
- Same load with rk_ready toggled pseudo-randomly: identical key sequence, outputs stable during stalls, exactly 11 accepts.
- Pulse start in EMIT at rk_round=5: ignored; sequence continues and completes unchanged.
- Assert rst while rk_round=6: all outputs 0 immediately (async). A fresh start afterwards produces the correct full sequence.
- FIPS-197 vector key_in=2b7e151628aed2a6abf7158809cf4f3c:
  - Round 0 emitted equals key_in.
  - Round 10 emitted equals d014f9a8c9ee2589e13f0cc8b6630ca6.
  - With AES_INV_KS_FWD_EN, loading the cipher key yields the same round-10 key 11 cycles after start.
